// File: rtl/tm_infer_sched.sv
// tm_infer_sched: sequential Tsetlin-machine inference scheduler.
// Eight 4-bit exclude registers (clauses 0..3 vote for class 0, 4..7 for
// class 1) are evaluated one clause per cycle against a latched 2-bit feature
// sample. The two class sums are then compared to produce final_class.
// Optional build macro: TM_SUM_OUT_EN adds the sum0_o / sum1_o outputs.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid stays high, and
// final_class stays stable, until out_ready is seen.
module tm_infer_sched (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr_en,
  input  logic [2:0]        cfg_addr,
  input  logic [3:0]        cfg_data,
  output logic              cfg_drop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        features,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        final_class,
  output logic              busy,
`ifdef TM_SUM_OUT_EN
  output logic signed [2:0] sum0_o,
  output logic signed [2:0] sum1_o,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        bank [8];
  logic [2:0]        k;
  logic [1:0]        feat;
  logic signed [2:0] sum0;
  logic signed [2:0] sum1;

  logic [3:0]        excl;
  logic [3:0]        lits;
  logic              fire;
  logic signed [2:0] vote;

  assign dbg_state = state;

`ifdef TM_SUM_OUT_EN
  assign sum0_o = sum0;
  assign sum1_o = sum1;
`endif

  // Clause k: AND of the non-excluded literals; fully excluded clause is 0.
  always_comb begin
    excl = bank[k];
    lits = {feat[1], ~feat[1], feat[0], ~feat[0]};
    fire = (&(lits | excl)) && (excl != 4'hF);
    vote = 3'sd0;
    if (fire) begin
      vote = k[0] ? 3'sb111 : 3'sd1;
    end
  end

  // Exclude bank: writable only in IDLE; other writes are dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        bank[i] <= 4'h0;
      end
      cfg_drop <= 1'b0;
    end else begin
      cfg_drop <= cfg_wr_en && (state != IDLE);
      if (cfg_wr_en && (state == IDLE)) begin
        bank[cfg_addr] <= cfg_data;
      end
    end
  end

  // Scheduler FSM: accept sample, walk the 8 clauses, present the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= 3'd0;
      feat        <= 2'b00;
      sum0        <= 3'sd0;
      sum1        <= 3'sd0;
      final_class <= 2'b00;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            feat     <= features;
            sum0     <= 3'sd0;
            sum1     <= 3'sd0;
            k        <= 3'd0;
            state    <= EVAL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        EVAL: begin
          if (!k[2]) begin
            sum0 <= sum0 + vote;
          end else begin
            sum1 <= sum1 + vote;
          end
          k <= k + 3'd1;
          if (k == 3'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle registers the verdict; later cycles wait for out_ready.
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (sum0 > sum1) begin
              final_class <= 2'b00;
            end else if (sum1 > sum0) begin
              final_class <= 2'b01;
            end else begin
              final_class <= 2'b10;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_infer_sched.sv
// tb_tm_infer_sched: directed and randomized checks of tm_infer_sched against
// a clause-by-clause arithmetic reference model of the classifier.
module tb_tm_infer_sched;

  logic              clk;
  logic              rst_n;
  logic              cfg_wr_en;
  logic [2:0]        cfg_addr;
  logic [3:0]        cfg_data;
  logic              cfg_drop;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        features;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        final_class;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef TM_SUM_OUT_EN
  logic signed [2:0] sum0_o;
  logic signed [2:0] sum1_o;
`endif

  int n_tests;
  int n_fail;
  logic [3:0] mdl_bank [8];
  logic [3:0] exp_q [$];

  tm_infer_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_drop    (cfg_drop),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .features    (features),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .final_class (final_class),
    .busy        (busy),
`ifdef TM_SUM_OUT_EN
    .sum0_o      (sum0_o),
    .sum1_o      (sum1_o),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference classifier: literal list {x1, ~x1, x2, ~x2}, bank bit 3 excludes x1.
  function automatic void model(input logic [1:0] f, output int cls,
                                output int s0, output int s1);
    int lit [4];
    int n_inc;
    int ok;
    lit[0] = int'(f[1]);
    lit[1] = 1 - int'(f[1]);
    lit[2] = int'(f[0]);
    lit[3] = 1 - int'(f[0]);
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 8; i++) begin
      n_inc = 0;
      ok = 1;
      for (int j = 0; j < 4; j++) begin
        if (mdl_bank[i][3 - j] == 1'b0) begin
          n_inc++;
          if (lit[j] == 0) ok = 0;
        end
      end
      if (n_inc > 0 && ok == 1) begin
        if (i < 4) s0 += ((i % 2) == 0) ? 1 : -1;
        else       s1 += ((i % 2) == 0) ? 1 : -1;
      end
    end
    if (s0 > s1)      cls = 0;
    else if (s1 > s0) cls = 1;
    else              cls = 2;
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    mdl_bank[a] = d;
    chk("cfg_drop_idle", int'(cfg_drop), 0);
  endtask

  task automatic load_bank();
    for (int i = 0; i < 8; i++) begin
      cfg_write(3'(i), exp_q.pop_front());
    end
  endtask

  // One full transaction: handshake, optional same-cycle cfg write, optional
  // dropped write at EVAL cycle drop_cyc, output held for hold cycles.
  task automatic run_sample(input logic [1:0] f, input int hold, input int drop_cyc,
                            input bit same_cfg, input logic [2:0] ca, input logic [3:0] cd);
    int cyc;
    int cls, s0, s1;
    bit got;
    @(negedge clk);
    features = f;
    in_valid = 1'b1;
    if (same_cfg) begin
      cfg_wr_en = 1'b1;
      cfg_addr  = ca;
      cfg_data  = cd;
      mdl_bank[ca] = cd;
    end
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_wr_en = 1'b0;
    chk("in_ready_eval", int'(in_ready), 0);
    chk("busy_eval", int'(busy), 1);
    if (same_cfg) chk("cfg_drop_same", int'(cfg_drop), 0);
    model(f, cls, s0, s1);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      features = 2'($urandom_range(0, 3));
      if (cyc + 1 == drop_cyc) begin
        cfg_wr_en = 1'b1;
        cfg_addr  = 3'($urandom_range(0, 7));
        cfg_data  = 4'($urandom_range(0, 15));
      end else begin
        cfg_wr_en = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (drop_cyc > 0 && cyc == drop_cyc) chk("cfg_drop_pulse", int'(cfg_drop), 1);
      if (drop_cyc > 0 && cyc == drop_cyc + 1) chk("cfg_drop_clear", int'(cfg_drop), 0);
      if (out_valid) got = 1'b1;
    end
    cfg_wr_en = 1'b0;
    chk("latency", cyc, 9);
    if (!got) return;
    chk("final_class", int'(final_class), cls);
`ifdef TM_SUM_OUT_EN
    chk("sum0", int'(sum0_o), s0);
    chk("sum1", int'(sum1_o), s1);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_class", int'(final_class), cls);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_busy", int'(busy), 0);
  endtask

  // Abandon a sample with reset while clause 4 is being evaluated.
  task automatic reset_mid_eval();
    @(negedge clk);
    features = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl_bank[i] = 4'h0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) chk("rst_no_valid", int'(out_valid), 0);
    end
    chk("rst_quiet_valid", int'(out_valid), 0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_addr  = 3'd0;
    cfg_data  = 4'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    features  = 2'b00;
    for (int i = 0; i < 8; i++) mdl_bank[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cfg_drop", int'(cfg_drop), 0);
    chk("reset_final_class", int'(final_class), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);

    // Class 0 wins: clauses 0,2 include only x1.
    exp_q = '{4'h7, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    load_bank();
    run_sample(2'b10, 0, 0, 1'b0, 3'd0, 4'h0);

    // Mirrored into class 1.
    exp_q = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'h7, 4'hF};
    load_bank();
    run_sample(2'b10, 0, 0, 1'b0, 3'd0, 4'h0);

    // All excluded: tie for every feature pattern.
    exp_q = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    load_bank();
    for (int f = 0; f < 4; f++) run_sample(2'(f), 0, 0, 1'b0, 3'd0, 4'h0);

    // Dropped write in EVAL, then the same sample again proves the bank held.
    exp_q = '{4'h7, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    load_bank();
    run_sample(2'b10, 0, 3, 1'b0, 3'd0, 4'h0);
    run_sample(2'b10, 0, 0, 1'b0, 3'd0, 4'h0);

    // Output backpressure for 5 cycles.
    run_sample(2'b10, 5, 0, 1'b0, 3'd0, 4'h0);

    // Same-cycle write and handshake: sample must see the new entry 4.
    run_sample(2'b10, 0, 0, 1'b1, 3'd4, 4'h7);

    // Reset mid-EVAL clears the bank: the class-0 bank is gone, result ties.
    exp_q = '{4'h7, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    load_bank();
    reset_mid_eval();
    run_sample(2'b10, 0, 0, 1'b0, 3'd0, 4'h0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        cfg_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      run_sample(2'($urandom_range(0, 3)), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tm_infer_sched.md
TM_INFER_SCHED -- requirements
Module: tm_infer_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock; all state is updated on this edge.
REQ-003 Port: rst_n  in  1  synchronous active-low reset.
REQ-004 Port: cfg_wr_en  in  1  writes one exclude-state entry.
REQ-005 Port: cfg_addr  in  3  clause index 0..7; 0..3 = class 0, 4..7 = class 1.
REQ-006 Port: cfg_data  in  4  exclude state {x1, ~x1, x2, ~x2}; bit = 1 excludes that literal.
REQ-007 Port: cfg_drop  out  1  one-cycle pulse when a write is rejected.
REQ-008 Port: in_valid / in_ready  in / out  1 / 1  feature handshake.
REQ-009 Port: features  in  2  {x1, x2}; sampled on in_valid && in_ready.
REQ-010 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 Port: final_class  out  2  00 = class 0, 01 = class 1, 10 = tie; 11 is never driven.
REQ-012 Port: busy  out  1  high in EVAL or DONE.

Function
REQ-013 The bank SHALL hold 8 x 4-bit exclude registers, written in IDLE only, and a write SHALL be visible to the next accepted sample.
REQ-014 A write outside IDLE SHALL be dropped and SHALL pulse cfg_drop for one cycle.
REQ-015 The FSM SHALL have three states: IDLE, EVAL and DONE.
- IDLE: in_ready = 1.
- Handshake in IDLE: latch features, clear sums, clear counter k, go to EVAL.
REQ-016 In EVAL, clause k SHALL be evaluated once per cycle, k = 0..7, and the state SHALL go to DONE after k = 7.
REQ-017 Clause output SHALL be the AND of all non-excluded literals; a clause with exclude = 1111 SHALL output 0.
REQ-018 Even k SHALL be a positive vote (+1) and odd k a negative vote (-1).
- k 0..3 accumulate into sum0.
- k 4..7 accumulate into sum1.
- Each sum is 3-bit signed, range -2..+2, and cannot overflow.
REQ-019 In DONE, the block SHALL drive out_valid = 1 and hold final_class stable until out_ready.
- final_class = 00 if sum0 > sum1, 01 if sum1 > sum0, 10 if equal.
REQ-020 On out_valid && out_ready the state SHALL return to IDLE; in_ready SHALL be asserted the cycle after.
REQ-021 Latency SHALL be: input accepted at edge T, out_valid high from edge T+9.
REQ-022 in_ready SHALL be 0 in EVAL and DONE, so there is no overlap between samples.
REQ-023 Features changing during EVAL or DONE SHALL have no effect.
REQ-024 A cfg write and an input handshake in the same IDLE cycle SHALL both be accepted, and the sample SHALL use the new value.

Reset
REQ-025 With rst_n = 0 at an edge, the state SHALL be IDLE.
- Cleared to 0: all exclude registers, sums, k, latched features, final_class, out_valid, cfg_drop, busy.
- in_ready = 1 from the first edge with rst_n = 1.
REQ-026 Reset during EVAL or DONE SHALL abandon the sample with no out_valid and SHALL clear the bank.

Configuration
REQ-027 With macro TM_SUM_OUT_EN defined, the block SHALL add outputs sum0_o and sum1_o (3-bit signed each).
- Both are valid with out_valid and reset to 0.
REQ-028 Without TM_SUM_OUT_EN, those ports and their logic SHALL be absent, with no other change.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Bank: entries 0,2 = 0111; entries 1,3,4..7 = 1111; features = 10 -> final_class = 00, sum0 = +2, sum1 = 0, out_valid at T+9.
- Bank mirrored into entries 4,6 (0111), all others 1111; features = 10 -> final_class = 01.
- All entries 1111; any features -> final_class = 10, sums 0.
- cfg_wr_en asserted in EVAL -> cfg_drop pulse, bank unchanged, result unchanged.
- out_ready held low 5 cycles -> out_valid and final_class stable, in_ready = 0; release -> IDLE next cycle.
- rst_n low at EVAL k = 4 -> no out_valid, bank reads 0000, in_ready = 1 after release.
